// File: rtl/backscatter_tx_scheduler.sv
// Trigger-aligned backscatter frame sequencer.
// A payload word is accepted, armed, and after a trigger edge plus a fixed
// preamble window it is driven MSB-first onto the RF switch at a fixed bit rate.
module backscatter_tx_scheduler #(
    parameter int unsigned FRAME_BITS   = 16,
    parameter int unsigned DELAY_CYCLES = 1920,
    parameter int unsigned BIT_CYCLES   = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  trigger_signal,
    input  logic [FRAME_BITS-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  signal_into_switch,
    output logic                  tx_active,
    output logic                  bit_strobe,
    output logic                  frame_done,
    output logic                  trigger_miss
);

    localparam int unsigned DW = $clog2(DELAY_CYCLES + 1);
    localparam int unsigned HW = $clog2(BIT_CYCLES + 1);
    localparam int unsigned BW = $clog2(FRAME_BITS + 1);

    localparam logic [DW-1:0] DELAY_LAST = DW'(DELAY_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic                  trig_meta;
    logic                  trig_sync;
    logic                  trig_sync_q;
    logic                  trig_edge;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [DW-1:0]         delay_cnt;
    logic [DW-1:0]         delay_nxt;
    logic [HW-1:0]         hold_cnt;
    logic [HW-1:0]         hold_nxt;
    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         bit_nxt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] shreg_nxt;
    logic [FRAME_BITS-1:0] shreg_sh;

    logic                  ready_nxt;
    logic                  sig_nxt;
    logic                  tx_nxt;
    logic                  strobe_nxt;
    logic                  done_nxt;
    logic                  miss_nxt;

    // Two-flop synchronizer plus registered rising-edge detect on the trigger.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trig_meta   <= 1'b0;
            trig_sync   <= 1'b0;
            trig_sync_q <= 1'b0;
            trig_edge   <= 1'b0;
        end else begin
            trig_meta   <= trigger_signal;
            trig_sync   <= trig_meta;
            trig_sync_q <= trig_sync;
            trig_edge   <= trig_sync & ~trig_sync_q;
        end
    end

    // Next-state, counter and output decode for the frame sequencer.
    always_comb begin
        state_nxt  = state;
        delay_nxt  = delay_cnt;
        hold_nxt   = hold_cnt;
        bit_nxt    = bit_cnt;
        shreg_nxt  = shreg;
        shreg_sh   = shreg << 1;
        ready_nxt  = data_ready;
        sig_nxt    = signal_into_switch;
        tx_nxt     = tx_active;
        strobe_nxt = 1'b0;
        done_nxt   = 1'b0;
        miss_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                ready_nxt = 1'b1;
                sig_nxt   = 1'b0;
                tx_nxt    = 1'b0;
                // No frame is armed yet, so an edge here is always lost,
                // even when a payload is accepted on the same edge.
                if (trig_edge) begin
                    miss_nxt = 1'b1;
                end
                if (data_valid && data_ready) begin
                    shreg_nxt = data_in;
                    ready_nxt = 1'b0;
                    delay_nxt = '0;
                    hold_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = S_ARMED;
                end
            end

            S_ARMED: begin
                ready_nxt = 1'b0;
                if (trig_edge) begin
                    delay_nxt = '0;
                    state_nxt = S_DELAY;
                end
            end

            S_DELAY: begin
                if (trig_edge) begin
                    miss_nxt = 1'b1;
                end
                if (delay_cnt == DELAY_LAST) begin
                    delay_nxt  = '0;
                    hold_nxt   = '0;
                    bit_nxt    = '0;
                    sig_nxt    = shreg[FRAME_BITS-1];
                    tx_nxt     = 1'b1;
                    strobe_nxt = 1'b1;
                    state_nxt  = S_SHIFT;
                end else begin
                    delay_nxt = delay_cnt + DW'(1);
                end
            end

            S_SHIFT: begin
                if (trig_edge) begin
                    miss_nxt = 1'b1;
                end
                if (hold_cnt == HOLD_LAST) begin
                    hold_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt   = '0;
                        sig_nxt   = 1'b0;
                        tx_nxt    = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        // Next bit follows immediately, no idle gap.
                        shreg_nxt  = shreg_sh;
                        sig_nxt    = shreg_sh[FRAME_BITS-1];
                        bit_nxt    = bit_cnt + BW'(1);
                        strobe_nxt = 1'b1;
                    end
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end

            S_DONE: begin
                if (trig_edge) begin
                    miss_nxt = 1'b1;
                end
                delay_nxt = '0;
                hold_nxt  = '0;
                bit_nxt   = '0;
                ready_nxt = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                delay_nxt = '0;
                hold_nxt  = '0;
                bit_nxt   = '0;
                ready_nxt = 1'b1;
                sig_nxt   = 1'b0;
                tx_nxt    = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters, payload and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            delay_cnt          <= '0;
            hold_cnt           <= '0;
            bit_cnt            <= '0;
            shreg              <= '0;
            data_ready         <= 1'b1;
            signal_into_switch <= 1'b0;
            tx_active          <= 1'b0;
            bit_strobe         <= 1'b0;
            frame_done         <= 1'b0;
            trigger_miss       <= 1'b0;
        end else begin
            state              <= state_nxt;
            delay_cnt          <= delay_nxt;
            hold_cnt           <= hold_nxt;
            bit_cnt            <= bit_nxt;
            shreg              <= shreg_nxt;
            data_ready         <= ready_nxt;
            signal_into_switch <= sig_nxt;
            tx_active          <= tx_nxt;
            bit_strobe         <= strobe_nxt;
            frame_done         <= done_nxt;
            trigger_miss       <= miss_nxt;
        end
    end

endmodule

// File: tb/tb_backscatter_tx_scheduler.sv
// Scoreboard bench for backscatter_tx_scheduler: stimulus pushes expected
// frames / missed triggers / ready windows, a negedge monitor pops and compares.
module tb_backscatter_tx_scheduler;

    localparam int unsigned FB  = 8;
    localparam int unsigned DC  = 4;
    localparam int unsigned BC  = 3;
    localparam int unsigned DC6 = 1;
    localparam int unsigned BC6 = 1;
    localparam int          BIG = 2147483647;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       trigger_signal;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       signal_into_switch;
    logic       tx_active;
    logic       bit_strobe;
    logic       frame_done;
    logic       trigger_miss;

    logic       reset6;
    logic       trigger6;
    logic [7:0] data_in6;
    logic       data_valid6;
    logic       data_ready6;
    logic       switch6;
    logic       tx_active6;
    logic       bit_strobe6;
    logic       frame_done6;
    logic       trigger_miss6;

    backscatter_tx_scheduler #(.FRAME_BITS(FB), .DELAY_CYCLES(DC), .BIT_CYCLES(BC)) dut (
        .clock(clock), .reset(reset), .trigger_signal(trigger_signal),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .signal_into_switch(signal_into_switch), .tx_active(tx_active),
        .bit_strobe(bit_strobe), .frame_done(frame_done), .trigger_miss(trigger_miss)
    );

    backscatter_tx_scheduler #(.FRAME_BITS(FB), .DELAY_CYCLES(DC6), .BIT_CYCLES(BC6)) dut6 (
        .clock(clock), .reset(reset6), .trigger_signal(trigger6),
        .data_in(data_in6), .data_valid(data_valid6), .data_ready(data_ready6),
        .signal_into_switch(switch6), .tx_active(tx_active6),
        .bit_strobe(bit_strobe6), .frame_done(frame_done6), .trigger_miss(trigger_miss6)
    );

    typedef struct {
        int         start;
        logic [7:0] data;
    } frame_t;

    frame_t fq[$];
    int     missq[$];
    int     rlo[$];
    int     rhi[$];

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    bit         loaded;
    bit         hold_valid;
    int         arm_edge;
    logic [7:0] loaded_data;

    int         st, st2, c0, a6, k6, st6, dn6;
    logic [3:0] fe6;
    logic [5:0] exp6;

    always @(posedge clock) cyc <= cyc + 1;

    // Expected {tx_active, switch, bit_strobe, frame_done} for a frame whose
    // first bit starts at 'start'.
    function automatic logic [3:0] frame_exp(input int c, input int start,
                                             input logic [7:0] d, input int bits,
                                             input int bc);
        int off;
        int idx;
        off = c - start;
        if (off >= 0 && off < bits * bc) begin
            idx = bits - 1 - off / bc;
            return {1'b1, d[idx], ((off % bc) == 0), 1'b0};
        end
        if (off == bits * bc) return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual{rdy,sw,tx,stb,done,miss}=%b required=%b",
                     name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int t);
        if (cyc > t) begin
            checks++;
            errors++;
            $display("FAIL wait_until target=%0d actual=%0d", t, cyc);
        end
        while (cyc < t) tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        trigger_signal = 1'b0;
        data_valid = 1'b0;
        #1;
        check("reset_now", {data_ready, signal_into_switch, tx_active, bit_strobe,
                            frame_done, trigger_miss}, 6'b100000);
        fq.delete();
        missq.delete();
        rlo.delete();
        rhi.delete();
        loaded = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic load(input logic [7:0] d);
        data_in = d;
        data_valid = 1'b1;
        tick(1);
        loaded = 1'b1;
        arm_edge = cyc;
        loaded_data = d;
        rlo.push_back(cyc);
        rhi.push_back(BIG);
        if (!hold_valid) data_valid = 1'b0;
    endtask

    // Raise the trigger; the model decides whether it starts a frame or is missed.
    task automatic fire(output int start);
        int k;
        int ke;
        int done;
        trigger_signal = 1'b1;
        k = cyc + 1;
        ke = k + 3;
        start = -1;
        if (loaded && arm_edge < ke) begin
            start = ke + DC;
            done = start + FB * BC;
            fq.push_back('{start, loaded_data});
            rhi[rhi.size() - 1] = done;
            loaded = 1'b0;
            if (hold_valid) begin
                loaded = 1'b1;
                arm_edge = done + 2;
                rlo.push_back(done + 2);
                rhi.push_back(BIG);
            end
        end else begin
            missq.push_back(ke);
        end
        tick(3);
        trigger_signal = 1'b0;
    endtask

    // Monitor: compare every output each cycle against the scoreboard heads.
    always @(negedge clock) begin : mon
        logic [5:0] exp;
        logic [3:0] fe;
        bit         rdy;
        if (!reset) begin
            while (rhi.size() > 0 && rhi[0] < cyc) begin
                void'(rlo.pop_front());
                void'(rhi.pop_front());
            end
            rdy = !(rlo.size() > 0 && rlo[0] <= cyc);
            fe = 4'b0000;
            if (fq.size() > 0) fe = frame_exp(cyc, fq[0].start, fq[0].data, FB, BC);
            exp = {rdy, fe[2], fe[3], fe[1], fe[0], 1'b0};
            if (missq.size() > 0 && missq[0] == cyc) begin
                exp[0] = 1'b1;
                void'(missq.pop_front());
            end
            check("outputs", {data_ready, signal_into_switch, tx_active, bit_strobe,
                              frame_done, trigger_miss}, exp);
            if (fe[0]) void'(fq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        trigger_signal = 1'b0;
        data_in = 8'h00;
        data_valid = 1'b0;
        hold_valid = 1'b0;
        loaded = 1'b0;
        reset6 = 1'b1;
        trigger6 = 1'b0;
        data_in6 = 8'h00;
        data_valid6 = 1'b0;

        do_reset();

        // Basic frame.
        load(8'hA5);
        tick(2);
        fire(st);
        wait_until(st + FB * BC + 4);

        // Trigger with nothing loaded.
        fire(st);
        tick(6);

        // Second trigger during bit 3 is ignored.
        load(8'hFF);
        tick(1);
        fire(st);
        wait_until(st + 6);
        fire(st2);
        wait_until(st + FB * BC + 4);

        // Reset in the middle of bit 5, then a clean frame.
        do_reset();
        load(8'h0F);
        fire(st);
        wait_until(st + 16);
        do_reset();
        load(8'h81);
        tick(1);
        fire(st);
        wait_until(st + FB * BC + 4);

        // Continuous valid, two triggers 50 cycles apart.
        hold_valid = 1'b1;
        load(8'h3C);
        tick(2);
        c0 = cyc;
        fire(st);
        wait_until(c0 + 50);
        fire(st2);
        wait_until(st2 + FB * BC + 5);
        hold_valid = 1'b0;
        data_valid = 1'b0;
        do_reset();

        // Random frames, occasionally with an extra trigger mid-frame.
        for (int i = 0; i < 6; i++) begin
            load(8'($urandom_range(0, 255)));
            tick(int'($urandom_range(0, 3)));
            fire(st);
            if ($urandom_range(0, 1) == 1) begin
                wait_until(st + int'($urandom_range(0, FB * BC - 4)));
                fire(st2);
            end
            wait_until(st + FB * BC + 3);
        end

        // Fast-rate instance: BIT_CYCLES=1, DELAY_CYCLES=1.
        reset6 = 1'b0;
        tick(2);
        data_in6 = 8'h96;
        data_valid6 = 1'b1;
        tick(1);
        a6 = cyc;
        data_valid6 = 1'b0;
        tick(1);
        trigger6 = 1'b1;
        k6 = cyc + 1;
        st6 = k6 + 3 + DC6;
        dn6 = st6 + FB * BC6;
        while (cyc < dn6 + 3) begin
            @(negedge clock);
            if (cyc >= k6 + 3) trigger6 = 1'b0;
            fe6 = frame_exp(cyc, st6, 8'h96, FB, BC6);
            exp6 = {!(cyc >= a6 && cyc <= dn6), fe6[2], fe6[3], fe6[1], fe6[0], 1'b0};
            check("fast_rate", {data_ready6, switch6, tx_active6, bit_strobe6,
                                frame_done6, trigger_miss6}, exp6);
        end

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
